// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg
// Shared definitions for the fetch-PC redirect block.
//   taken_type_e : encoding of the branch/jal resolution bus
//   state_e      : redirect FSM states
//   align_target : clears the two low bits of a target address
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    TT_NONE    = 2'b00,
    TT_BRANCH  = 2'b01,
    TT_JAL     = 2'b10,
    TT_ILLEGAL = 2'b11
  } taken_type_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/redirect_fsm.sv
// redirect_fsm
// State register and flush counter of the PC redirect block. Decides each
// cycle what the PC register in the parent does.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : pipeline stall, freezes FSM progress
//   redir             : a taken branch/jal is presented this cycle
//   apply_live        : load PC from the target presented this cycle
//   apply_pend        : load PC from the latched pending target
//   latch_pend        : capture the presented target into the pending register
//   advance           : PC += 4
//   flush             : registered squash indication
//   redirect_pending  : registered, a redirect waits for stall release
module redirect_fsm
  import pc_redirect_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic redir,
  output logic apply_live,
  output logic apply_pend,
  output logic latch_pend,
  output logic advance,
  output logic flush,
  output logic redirect_pending
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    apply_live = 1'b0;
    apply_pend = 1'b0;
    latch_pend = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redir) begin
          if (stall) begin
            latch_pend = 1'b1;
            state_d    = HOLD;
          end else begin
            apply_live = 1'b1;
            state_d    = FLUSH;
            cnt_d      = FLUSH_INIT;
          end
        end else if (!stall) begin
          advance = 1'b1;
        end
      end
      // New redirects are ignored here: the first latched one wins.
      HOLD: begin
        if (!stall) begin
          apply_pend = 1'b1;
          state_d    = FLUSH;
          cnt_d      = FLUSH_INIT;
        end
      end
      // Redirect requests here come from wrong-path instructions; ignore them.
      FLUSH: begin
        if (!stall) begin
          advance = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage boundary: state, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      cnt_q            <= 3'd0;
      flush            <= 1'b0;
      redirect_pending <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flush            <= (state_d == FLUSH);
      redirect_pending <= (state_d == HOLD);
    end
  end

endmodule

// File: rtl/pc_redirect.sv
// pc_redirect
// Fetch PC register with branch/jal redirect, stall-deferred redirects and
// a fixed-length pipeline flush after every redirect.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : holds PC and FSM progress
//   taken_type        : 00 none, 01 branch, 10 jal, 11 illegal (= none)
//   branch_target     : destination for taken_type 01
//   jal_target        : destination for taken_type 10
//   pc                : current fetch PC (registered)
//   flush             : squash IF/ID and ID/EX (registered)
//   redirect_pending  : redirect latched, waiting for stall release
//   misaligned        : one-cycle pulse with the PC load of a target whose
//                       low two bits were nonzero
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  taken_type,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  output logic [31:0] pc,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misaligned
);

  logic        is_redir;
  logic [31:0] sel_target;
  logic [31:0] pend_target_p1;
  logic        apply_live, apply_pend, latch_pend, advance;

  assign is_redir   = (taken_type == TT_BRANCH) || (taken_type == TT_JAL);
  assign sel_target = (taken_type == TT_JAL) ? jal_target : branch_target;

  redirect_fsm #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_fsm (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redir            (is_redir),
    .apply_live       (apply_live),
    .apply_pend       (apply_pend),
    .latch_pend       (latch_pend),
    .advance          (advance),
    .flush            (flush),
    .redirect_pending (redirect_pending)
  );

  // Stage boundary: PC, pending target and misalignment pulse.
  // The pending target is kept unaligned so misalignment is reported when
  // it is finally applied, in step with the PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      pend_target_p1 <= 32'h0;
      misaligned     <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (apply_live) begin
        pc         <= align_target(sel_target);
        misaligned <= |sel_target[1:0];
      end else if (apply_pend) begin
        pc         <= align_target(pend_target_p1);
        misaligned <= |pend_target_p1[1:0];
      end else if (advance) begin
        pc <= pc + 32'd4;
      end
      if (latch_pend) pend_target_p1 <= sel_target;
    end
  end

endmodule

// File: tb/tb_pc_redirect.sv
module tb_pc_redirect;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 2;

  logic        clk;
  logic        rst, stall;
  logic [1:0]  tt;
  logic [31:0] bt, jt;
  logic [31:0] pc;
  logic        flush, rp, mis;

  pc_redirect #(
    .RESET_PC     (RST_PC),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .taken_type       (tt),
    .branch_target    (bt),
    .jal_target       (jt),
    .pc               (pc),
    .flush            (flush),
    .redirect_pending (rp),
    .misaligned       (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: a redirect either waits (pending) or has been applied,
  // after which a number of unstalled flush cycles remain.
  logic [31:0] m_pc;
  logic [31:0] m_pt;
  bit          m_pv;
  int          m_left;
  bit          m_mis;
  bit          model_ok = 0;

  always @(posedge clk) begin
    bit          taken;
    logic [31:0] tgt;
    m_mis = 0;
    if (rst) begin
      m_pc = RST_PC; m_left = 0; m_pv = 0; m_pt = 32'h0;
      model_ok = 1;
    end else if (m_pv) begin
      if (!stall) begin
        m_pc = m_pt & 32'hFFFF_FFFC; m_mis = (m_pt[1:0] != 2'b00);
        m_pv = 0; m_left = FC;
      end
    end else if (m_left > 0) begin
      if (!stall) begin m_pc = m_pc + 32'd4; m_left = m_left - 1; end
    end else begin
      taken = (tt == 2'd1) || (tt == 2'd2);
      tgt   = (tt == 2'd2) ? jt : bt;
      if (taken && stall) begin
        m_pv = 1; m_pt = tgt;
      end else if (taken) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_mis = (tgt[1:0] != 2'b00); m_left = FC;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Hand-computed expectations handed to the compare process.
  logic [31:0] l_pc;
  logic        l_flush, l_rp, l_mis;
  string       l_name;
  int          lit_req = 0;
  int          lit_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("pc",               pc,           m_pc);
      chk("flush",            32'(flush),   32'(m_left > 0));
      chk("redirect_pending", 32'(rp),      32'(m_pv));
      chk("misaligned",       32'(mis),     32'(m_mis));
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      chk({l_name, ".pc"},    pc,         l_pc);
      chk({l_name, ".flush"}, 32'(flush), 32'(l_flush));
      chk({l_name, ".rp"},    32'(rp),    32'(l_rp));
      chk({l_name, ".mis"},   32'(mis),   32'(l_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [31:0] p,
                            input logic f, input logic r, input logic m);
    l_name = name; l_pc = p; l_flush = f; l_rp = r; l_mis = m;
    lit_req++;
  endtask

  task automatic drive(input logic s, input logic [1:0] t,
                       input logic [31:0] b, input logic [31:0] j);
    stall = s; tt = t; bt = b; jt = j;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("reset", 32'h0, 0, 0, 0);
    rst = 0;
    tick(); expect_lit("idle1", 32'h4, 0, 0, 0);
    tick(); expect_lit("idle2", 32'h8, 0, 0, 0);
    tick(); expect_lit("idle3", 32'hC, 0, 0, 0);
    tick();                                              // pc 0x10
    drive(0, 2'd1, 32'h40, 32'h0);
    tick(); expect_lit("br_load", 32'h40, 1, 0, 0);
    drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("br_fl2", 32'h44, 1, 0, 0);
    tick(); expect_lit("br_done", 32'h48, 0, 0, 0);
    // bring pc to 0x20 through a second branch
    drive(0, 2'd1, 32'h18, 32'h0); tick();
    drive(0, 2'd0, 32'h0, 32'h0); tick(); tick();
    expect_lit("at20", 32'h20, 0, 0, 0);
    // stalled jal: held three cycles, later requests ignored
    drive(1, 2'd2, 32'h999, 32'h100); tick();
    expect_lit("hold1", 32'h20, 0, 1, 0);
    drive(1, 2'd1, 32'h200, 32'h300); tick(); tick();
    expect_lit("hold3", 32'h20, 0, 1, 0);
    drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("jal_load", 32'h100, 1, 0, 0);
    tick(); expect_lit("jal_fl2", 32'h104, 1, 0, 0);
    drive(1, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("fl_stall", 32'h104, 1, 0, 0);
    drive(0, 2'd1, 32'h80, 32'h0);                      // wrong-path branch
    tick(); expect_lit("fl_ignore", 32'h108, 0, 0, 0);
    // misaligned live branch
    drive(0, 2'd1, 32'h43, 32'h0);
    tick(); expect_lit("mis_br", 32'h40, 1, 0, 1);
    drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("mis_clr", 32'h44, 1, 0, 0);
    tick();                                              // pc 0x48, run
    // misaligned jal via hold
    drive(1, 2'd2, 32'h0, 32'h202); tick();
    drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("mis_jal", 32'h200, 1, 0, 1);
    tick(); tick();
    // reset during HOLD
    drive(1, 2'd1, 32'h300, 32'h0); tick();
    rst = 1; tick(); expect_lit("rst_hold", RST_PC, 0, 0, 0);
    rst = 0; drive(0, 2'd0, 32'h0, 32'h0);
    tick(); expect_lit("after_rst_hold", 32'h4, 0, 0, 0);
    // reset during FLUSH
    drive(0, 2'd1, 32'h500, 32'h0); tick();
    drive(0, 2'd0, 32'h0, 32'h0);
    rst = 1; tick(); expect_lit("rst_flush", RST_PC, 0, 0, 0);
    rst = 0;
    tick(); expect_lit("after_rst_flush", 32'h4, 0, 0, 0);
    // 32-bit wrap
    drive(0, 2'd2, 32'h0, 32'hFFFF_FFF4); tick();
    drive(0, 2'd0, 32'h0, 32'h0); tick(); tick();
    expect_lit("pre_wrap", 32'hFFFF_FFFC, 0, 0, 0);
    tick(); expect_lit("wrap", 32'h0, 0, 0, 0);
    // illegal encoding behaves as not taken, also under stall
    drive(0, 2'd3, 32'h700, 32'h800);
    tick(); expect_lit("illegal", 32'h4, 0, 0, 0);
    drive(1, 2'd3, 32'h700, 32'h800);
    tick(); expect_lit("illegal_stall", 32'h4, 0, 0, 0);
    drive(0, 2'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
